ai_action_scheduler: RTL
========================

// Module: ai_action_scheduler
// PURPOSE
//  Queues action codes from the AI policy engine and issues them one at a time to the AI action decoder.
//  Each code is driven for exactly one cycle; the scheduler then waits for the game FSM to report completion.
//  Issue is gated by AI turn ownership and game-busy. Lost turn flushes the queue; a stuck action times out.
// PARAMETERS
//  DEPTH        4           action FIFO entries (power of 2, >=2)
//  TIMEOUT_CYC  50_000_000  max cycles in WAIT_DONE before abort (1 s @ 50 MHz)
//  GAP_CYC      2_000_000   idle cycles between consecutive issues (visual pacing)
// PORTS
//  clk            in   1              system clock, rising edge
//  rst            in   1              synchronous reset, active-high
//  i_ai_valid     in   1              AI presents i_ai_action this cycle
//  i_ai_action    in   4              0 shoot enemy, 1 shoot self, 2..8 use item (id=code-2), 9 item shoot, 15 idle
//  o_ai_ready     out  1              FIFO can accept (not full)
//  i_ai_turn      in   1              game FSM: AI owns the turn
//  i_game_busy    in   1              game FSM animating/resolving; no issue while high
//  i_action_done  in   1              1-cycle pulse: last issued action resolved
//  o_action       out  4              to decoder; 15 except on the single issue cycle
//  o_busy         out  1              FSM not in IDLE or FIFO non-empty
//  o_timeout      out  1              1-cycle pulse on WAIT_DONE abort
//  o_drop         out  1              1-cycle pulse: accepted code 10..14 discarded
//  o_fifo_count   out  $clog2(DEPTH)+1  entries queued
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): FIFO empty, state IDLE, counters 0.
//  Reset values: o_action=15, o_ai_ready=1, o_busy=0, o_timeout=0, o_drop=0, o_fifo_count=0.
//  Accept: handshake = i_ai_valid & o_ai_ready. Codes 0..9 are pushed.
//   Codes 10..14 are not pushed; o_drop pulses the next cycle. Code 15 is ignored silently.
//  o_ai_ready = !full. Push on full is impossible by handshake; no overwrite.
//  Simultaneous push and pop: count unchanged, both take effect. Pointers wrap modulo DEPTH.
//  FSM:
//   IDLE -> ISSUE when !empty & i_ai_turn & !i_game_busy. Pop head into o_action (registered).
//   ISSUE (1 cycle, o_action=code) -> WAIT_DONE. o_action returns to 15.
//   WAIT_DONE -> GAP on i_action_done. Timer increments each cycle.
//    At timer==TIMEOUT_CYC-1 without done: pulse o_timeout, go to GAP.
//   GAP counts GAP_CYC cycles -> IDLE.
//  Latency: push into empty FIFO at edge N (IDLE, gate true) -> o_action valid during cycle after edge N+1.
//  i_action_done seen in the ISSUE cycle counts as done (ISSUE -> GAP).
//  i_action_done outside ISSUE/WAIT_DONE is ignored.
//  Turn loss: i_ai_turn low in any state -> flush FIFO (count 0) and go to IDLE next edge.
//   No o_timeout; o_action=15. A same-cycle push is discarded.
//  i_game_busy only gates IDLE->ISSUE; it never aborts WAIT_DONE or GAP.
//  Timer is a single down/up counter, width $clog2(max(TIMEOUT_CYC,GAP_CYC))+1, cleared on every state entry.
//  All outputs registered; no combinational path from inputs to outputs except o_ai_ready (from count).
// STRUCTURE
//  ai_action_pkg: ACT_SHOOT_ENEMY=0, ACT_SHOOT_SELF=1, ACT_ITEM_BASE=2, ACT_ITEM_LAST=8,
//   ACT_ITEM_SHOOT=9, ACT_IDLE=15; typedef enum {S_IDLE,S_ISSUE,S_WAIT_DONE,S_GAP} sched_state_t.
//  Sub-module action_fifo (DEPTH x 4b, sync flush, count output).
//  FSM + timer live in this module.
// TESTING (bench params DEPTH=4, TIMEOUT_CYC=20, GAP_CYC=3)
//  1 Reset then turn=1, busy=0; push 0 at edge N -> o_action=0 for one cycle after N+1, then 15; o_busy=1.
//  2 Push 3,4,9 back-to-back; done 5 cyc after each issue -> issues in order 3,4,9, >=3 idle cycles between.
//  3 Push 2,2,2,2,5: after 4 pushes o_ai_ready=0, fifth held; accepted after first pop; count never >4.
//  4 Issue 1, never pulse done -> o_timeout pulses 20 cycles after ISSUE; next action issues after GAP.
//  5 Queue 6,7; drop i_ai_turn during WAIT_DONE -> count=0 next cycle, IDLE, no further issue; o_timeout stays 0.
//  6 Push 12 -> o_drop pulse, count stays 0. Push 15 -> nothing. busy=1 holds issue; release -> issue in 1 cycle.

Source files
------------

// File: rtl/ai_action_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ai_action_scheduler_pkg
//  Description : Action codes, scheduler states and code-class helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ai_action_scheduler_pkg;

    localparam int ACTION_W = 4;
    typedef logic [ACTION_W-1:0] action_t;

    localparam action_t ACT_SHOOT_ENEMY    = 4'd0;
    localparam action_t ACT_SHOOT_SELF     = 4'd1;
    localparam action_t ACT_ITEM_BASE      = 4'd2;
    localparam action_t ACT_ITEM_LAST      = 4'd8;
    localparam action_t ACT_ITEM_SHOOT     = 4'd9;
    localparam action_t ACT_RESERVED_FIRST = 4'd10;
    localparam action_t ACT_RESERVED_LAST  = 4'd14;
    localparam action_t ACT_IDLE           = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } sched_state_t;

    function automatic logic is_valid_code(input action_t a);
        return (a == ACT_SHOOT_ENEMY) || (a == ACT_SHOOT_SELF) ||
               ((a >= ACT_ITEM_BASE) && (a <= ACT_ITEM_LAST)) || (a == ACT_ITEM_SHOOT);
    endfunction

    function automatic logic is_reserved_code(input action_t a);
        return (a >= ACT_RESERVED_FIRST) && (a <= ACT_RESERVED_LAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ai_action_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : ai_action_scheduler_if
//  Description : Policy-engine and game-FSM side signals of the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ai_action_scheduler_if #(
    parameter int DEPTH = 4
);
    import ai_action_scheduler_pkg::*;

    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic               i_ai_valid;
    action_t            i_ai_action;
    logic               o_ai_ready;
    logic               i_ai_turn;
    logic               i_game_busy;
    logic               i_action_done;
    action_t            o_action;
    logic               o_busy;
    logic               o_timeout;
    logic               o_drop;
    logic [c_CNT_W-1:0] o_fifo_count;

    modport slave (
        input  i_ai_valid, i_ai_action, i_ai_turn, i_game_busy, i_action_done,
        output o_ai_ready, o_action, o_busy, o_timeout, o_drop, o_fifo_count
    );

    modport master (
        output i_ai_valid, i_ai_action, i_ai_turn, i_game_busy, i_action_done,
        input  o_ai_ready, o_action, o_busy, o_timeout, o_drop, o_fifo_count
    );

endinterface
`default_nettype wire

// File: rtl/ai_action_scheduler_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ai_action_scheduler_fifo
//  Description : DEPTH-entry action FIFO with synchronous flush and count.
//  Revision    : 1.0 - initial release
// ============================================================================
module ai_action_scheduler_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_flush,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_data,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_head,
    output logic      [$clog2(DEPTH):0]     o_count,
    output logic                            o_full,
    output logic                            o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Flush wins over both push and pop so a flushed cycle leaves nothing behind.
    assign w_push  = i_push & ~o_full  & ~i_flush;
    assign w_pop   = i_pop  & ~o_empty & ~i_flush;
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ai_action_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ai_action_scheduler
//  Description : Queues AI action codes and issues them one at a time,
//                gated by turn ownership, with completion wait and pacing.
//  Revision    : 1.0 - initial release
// ============================================================================
module ai_action_scheduler
    import ai_action_scheduler_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int GAP_CYC     = 2_000_000
) (
    input  wire logic            clk,
    input  wire logic            rst,
    ai_action_scheduler_if.slave sched
);

    localparam int c_CNT_W   = $clog2(DEPTH) + 1;
    localparam int c_TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX) + 1;
    localparam logic [c_TMR_W-1:0] c_TIMEOUT_LAST = c_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST     = c_TMR_W'(GAP_CYC - 1);

    sched_state_t       r_state;
    logic [c_TMR_W-1:0] r_timer;
    action_t            r_action;
    logic               r_busy;
    logic               r_timeout;
    logic               r_drop;

    logic               w_handshake;
    logic               w_push;
    logic               w_reserved;
    logic               w_flush;
    logic               w_start;
    action_t            w_head;
    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_full;
    logic               w_empty;

    assign w_handshake = sched.i_ai_valid & ~w_full;
    assign w_push      = w_handshake & is_valid_code(sched.i_ai_action);
    assign w_reserved  = w_handshake & is_reserved_code(sched.i_ai_action);
    assign w_flush     = ~sched.i_ai_turn;
    assign w_start     = (r_state == S_IDLE) & ~w_empty & sched.i_ai_turn & ~sched.i_game_busy;
    // Queue occupancy after this edge, so o_busy can be registered without lag.
    assign w_cnt_nxt   = w_flush ? '0 : (w_count + c_CNT_W'(w_push) - c_CNT_W'(w_start));

    ai_action_scheduler_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ACTION_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (sched.i_ai_action),
        .i_pop   (w_start),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_action  <= ACT_IDLE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_action  <= ACT_IDLE;
            r_timeout <= 1'b0;
            r_drop    <= w_reserved;
            if (w_flush) begin
                r_state <= S_IDLE;
                r_timer <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_timer <= '0;
                        if (w_start) begin
                            r_state  <= S_ISSUE;
                            r_action <= w_head;
                            r_busy   <= 1'b1;
                        end else begin
                            r_busy <= (w_cnt_nxt != '0);
                        end
                    end
                    S_ISSUE: begin
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                        r_state <= sched.i_action_done ? S_GAP : S_WAIT_DONE;
                    end
                    S_WAIT_DONE: begin
                        r_busy <= 1'b1;
                        if (sched.i_action_done) begin
                            r_state <= S_GAP;
                            r_timer <= '0;
                        end else if (r_timer == c_TIMEOUT_LAST) begin
                            r_state   <= S_GAP;
                            r_timer   <= '0;
                            r_timeout <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (r_timer == c_GAP_LAST) begin
                            r_state <= S_IDLE;
                            r_timer <= '0;
                            r_busy  <= (w_cnt_nxt != '0);
                        end else begin
                            r_timer <= r_timer + 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                        r_busy  <= (w_cnt_nxt != '0);
                    end
                endcase
            end
        end
    end

    assign sched.o_ai_ready   = ~w_full;
    assign sched.o_action     = r_action;
    assign sched.o_busy       = r_busy;
    assign sched.o_timeout    = r_timeout;
    assign sched.o_drop       = r_drop;
    assign sched.o_fifo_count = w_count;

endmodule
`default_nettype wire
